// File: rtl/toy_fetch_queue.sv
// ============================================================================
// toy_fetch_queue : sequential instruction fetch with a DEPTH-entry decode queue
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module toy_fetch_queue #(
   parameter int unsigned     AW       = 30,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic                           CLK,
   input  logic                           RSTN,
   output logic                           IREQ,
   output logic [AW-1:0]                  IADDR,
   input  logic [31:0]                    INSTR,
   input  logic                           REDIRECT,
   input  logic [AW-1:0]                  REDIRECT_PC,
   output logic                           DEQ_VALID,
   input  logic                           DEQ_READY,
   output logic [31:0]                    DEQ_INSTR,
   output logic [AW-1:0]                  DEQ_PC,
   output logic [$clog2(DEPTH+1)-1:0]     COUNT
);

   localparam int unsigned PW      = $clog2(DEPTH);
   localparam int unsigned CW      = $clog2(DEPTH+1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [AW-1:0] fpc_q, fpc_d;
   logic          run_q;
   logic          infl_q, infl_d;
   logic [AW-1:0] ipc_q, ipc_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   instr_mem_q [DEPTH];
   logic [AW-1:0] pc_mem_q    [DEPTH];

   logic credit;
   logic push;
   logic pop;

   always_comb begin
      // Credit counts the in-flight fetch but ignores a same-cycle pop
      credit    = ({1'b0, cnt_q} + {{CW{1'b0}}, infl_q}) < DEPTH_W;
      IREQ      = run_q & ~REDIRECT & credit;
      IADDR     = fpc_q;
      DEQ_VALID = (cnt_q != '0);
      DEQ_INSTR = instr_mem_q[rd_q];
      DEQ_PC    = pc_mem_q[rd_q];
      COUNT     = cnt_q;
      push      = infl_q & ~REDIRECT;
      pop       = DEQ_VALID & DEQ_READY;

      fpc_d  = fpc_q;
      infl_d = infl_q;
      ipc_d  = ipc_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;

      if (REDIRECT) begin
         fpc_d  = REDIRECT_PC;
         infl_d = 1'b0;
         rd_d   = '0;
         wr_d   = '0;
         cnt_d  = '0;
      end else begin
         infl_d = IREQ;
         if (IREQ) begin
            ipc_d = fpc_q;
            fpc_d = fpc_q + AW'(1);
         end
         if (push) begin
            wr_d = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
         end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         fpc_q  <= RESET_PC;
         run_q  <= 1'b0;
         infl_q <= 1'b0;
         ipc_q  <= '0;
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
      end else begin
         fpc_q  <= fpc_d;
         run_q  <= 1'b1;
         infl_q <= infl_d;
         ipc_q  <= ipc_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage needs no reset: count gates visibility of every entry
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_mem_q[wr_q] <= INSTR;
         pc_mem_q[wr_q]    <= ipc_q;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_toy_fetch_queue.sv
// ============================================================================
// tb_toy_fetch_queue : randomized scoreboard bench for toy_fetch_queue
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_toy_fetch_queue;

   localparam int            AW    = 30;
   localparam int            DEPTH = 4;
   localparam logic [AW-1:0] RPC   = 30'h3FFF_FFFE;

   logic          CLK;
   logic          RSTN;
   logic          IREQ;
   logic [AW-1:0] IADDR;
   logic [31:0]   INSTR;
   logic          REDIRECT;
   logic [AW-1:0] REDIRECT_PC;
   logic          DEQ_VALID;
   logic          DEQ_READY;
   logic [31:0]   DEQ_INSTR;
   logic [AW-1:0] DEQ_PC;
   logic [2:0]    COUNT;

   toy_fetch_queue #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .IREQ        (IREQ),
      .IADDR       (IADDR),
      .INSTR       (INSTR),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .DEQ_VALID   (DEQ_VALID),
      .DEQ_READY   (DEQ_READY),
      .DEQ_INSTR   (DEQ_INSTR),
      .DEQ_PC      (DEQ_PC),
      .COUNT       (COUNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [31:0]   instr;
   } ent_t;

   // Instructions expected at decode, oldest first
   ent_t          exp_q[$];
   int            n_cmp  = 0;
   int            n_fail = 0;
   logic          m_run;
   logic          m_infl;
   logic [AW-1:0] m_fpc;
   logic [AW-1:0] m_ipc;
   logic          e_ireq;
   logic          mem_req;
   logic [AW-1:0] mem_addr;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + {2'b00, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_run  = 1'b0;
      m_infl = 1'b0;
      m_fpc  = RPC;
      m_ipc  = '0;
   endtask

   // One clock cycle: drive at negedge, check at +1, advance the model at +3
   task automatic cycle(input logic rstn, input logic redir,
                        input logic [AW-1:0] rpc, input logic rdy);
      @(negedge CLK);
      RSTN        = rstn;
      REDIRECT    = redir;
      REDIRECT_PC = rpc;
      DEQ_READY   = rdy;
      INSTR       = mem_req ? mem_word(mem_addr) : $urandom;
      if (!rstn) model_reset();
      #1;
      e_ireq = m_run && !redir && ((exp_q.size() + int'(m_infl)) < DEPTH);
      chk("IREQ", 64'(IREQ), 64'(e_ireq));
      if (e_ireq) chk("IADDR", 64'(IADDR), 64'(m_fpc));
      chk("COUNT", 64'(COUNT), 64'(exp_q.size()));
      chk("DEQ_VALID", 64'(DEQ_VALID), 64'(exp_q.size() != 0));
      mem_req  = IREQ;
      mem_addr = IADDR;
      #2;
      if (rstn) begin
         if (redir) begin
            exp_q.delete();
            m_infl = 1'b0;
            m_fpc  = rpc;
         end else begin
            if (m_infl) exp_q.push_back('{pc: m_ipc, instr: mem_word(m_ipc)});
            if (e_ireq) begin
               m_infl = 1'b1;
               m_ipc  = m_fpc;
               m_fpc  = m_fpc + 1'b1;
            end else begin
               m_infl = 1'b0;
            end
         end
         m_run = 1'b1;
      end
   endtask

   always @(negedge CLK) begin
      #2;
      if (DEQ_VALID === 1'b1 && DEQ_READY === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL DEQ_UNEXPECTED: got pc %0h expected no entry at %0t", DEQ_PC, $time);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("DEQ_PC", 64'(DEQ_PC), 64'(e.pc));
            chk("DEQ_INSTR", 64'(DEQ_INSTR), 64'(e.instr));
         end
      end
   end

   initial begin
      RSTN        = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      DEQ_READY   = 1'b0;
      INSTR       = '0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      model_reset();

      repeat (2)  cycle(1'b0, 1'b0, '0, 1'b1);
      // Stream across the address wrap from RESET_PC
      repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);
      // Backpressure to full, single pop, one refill fetch
      repeat (8)  cycle(1'b1, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b0);
      // Redirect with COUNT=3 and a fetch in flight
      cycle(1'b1, 1'b1, 30'h100, 1'b0);
      repeat (8)  cycle(1'b1, 1'b0, '0, 1'b1);
      // Redirect coinciding with a dequeue handshake
      cycle(1'b1, 1'b1, 30'h0, 1'b1);
      repeat (6)  cycle(1'b1, 1'b0, '0, 1'b1);
      // Held redirect: last target wins
      cycle(1'b1, 1'b1, 30'h55, 1'b1);
      cycle(1'b1, 1'b1, 30'h66, 1'b0);
      cycle(1'b1, 1'b1, 30'h200, 1'b1);
      repeat (6)  cycle(1'b1, 1'b0, '0, 1'b1);
      // One-cycle reset pulse while streaming
      cycle(1'b0, 1'b0, '0, 1'b1);
      repeat (6)  cycle(1'b1, 1'b0, '0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) != 0,
               $urandom_range(0, 19) == 0,
               AW'($urandom),
               $urandom_range(0, 3) != 0);
      end
      repeat (DEPTH + 4) cycle(1'b1, 1'b0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
